load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer that drives the data port of the dual-port `ram` on behalf of the core's memory stage. It accepts one byte/halfword/word load or store at a time over a valid/ready request channel. It performs sub-word stores as read-modify-write, because `ram` has only a word-wide write enable. It returns sign- or zero-extended load data over a one-cycle response pulse. It is the initiator for the `ram` d-port; the i-port is untouched.

## Interface
- `ADDR_WIDTH`, 16: width of `ram` word address (`d_address`); must match the `ram` instance.
- `clock`  in  1  rising-edge clock shared with `ram`.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit idle and can accept.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load data; 0 for stores.
- `resp_misaligned`  out  1  request rejected, no memory access.
- `d_address`  out  ADDR_WIDTH  `req_addr[ADDR_WIDTH+1:2]`, latched.
- `d_read_data`  in  32  combinational `ram` read of `d_address`.
- `d_write_data`  out  32  merged word.
- `wEn`  out  1  `ram` writes `d_write_data` at the rising edge that ends a cycle with `wEn` high.

## Operation
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE: `req_ready`=1. Accept on `req_valid && req_ready`; latch all `req_*`.
- Misaligned or illegal requests go IDLE→RESP with `resp_misaligned`=1. This covers:
  - half with `addr[0]`=1;
  - word with `addr[1:0]`≠0;
  - size 11.
- Otherwise:
  - load → LOAD;
  - store word → WRITE;
  - store byte/half → RMW_READ.
- LOAD:
  - Select the lane from `d_read_data` by `addr[1:0]`.
  - Extend per `req_unsigned` and register into `resp_rdata`.
  - Go to RESP.
- RMW_READ:
  - Register `d_read_data` with the byte lane(s) at `addr[1:0]` replaced by `req_wdata[7:0]` / `[15:0]`.
  - Go to WRITE.
- WRITE: `wEn`=1, `d_write_data` = merged word (word store: `req_wdata`); go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, `req_ready`=0; go to IDLE.
- Lane numbering is little-endian: byte k = bits [8k+7:8k].
- Address bits above `ADDR_WIDTH+1` are ignored (wrap-around).
- `resp_rdata` and `resp_misaligned` hold until the next acceptance; only `resp_valid` pulses.

## Timing
- Acceptance edge = E0.
  - Misaligned: `resp_valid` in cycle after E0.
  - Load: data sampled in the cycle after E0; `resp_valid` after E1.
  - Word store: `wEn` high in the cycle after E0, write at E1, `resp_valid` after E1.
  - Sub-word store: read after E0, `wEn` after E1, write at E2, `resp_valid` after E2.
- Back-to-back: next acceptance earliest in the IDLE cycle following RESP.
  - Loads: throughput 1 per 3 cycles.
  - Sub-word stores: 1 per 4 cycles.
- `wEn` = (state==WRITE) && !reset. A reset asserted in the WRITE cycle suppresses the write.
- Reset values: state IDLE; `req_ready`, `resp_valid`, `resp_misaligned`, `wEn` all 0; `resp_rdata`, `d_address`, `d_write_data` all 0.
  - `req_ready` is gated by !reset.
- Reset mid-operation abandons the request: no response, no memory change.
- `req_*` changes while not ready are ignored.

## Structure
- `lsu_pkg`:
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - FSM state enum;
  - `DATA_WIDTH`=32.
- Sub-module `lsu_lane_align` (combinational): load extract/extend, store lane merge, misalignment detect. The FSM and registers live in `load_store_unit`.

## Test plan
- Preload word 1 = 8899AABB. LB addr 5 → `resp_rdata` FFFFFFAA. LBU addr 5 → 000000AA. LH addr 6 → FFFF8899. LHU addr 6 → 00008899. Each response comes after E1 with `wEn` never high.
- SB `req_wdata` 0000005A, addr 7 → `wEn` high after E1 only. Word 1 becomes 5A99AABB and is read back by LW 4.
- SW DEADBEEF addr 8 → `wEn` after E0, `resp_valid` after E1. LW 8 → DEADBEEF. SH FFFFFFFF addr 0xA → word 2 becomes FFFFBEEF.
- LW addr 6, SH addr 3, size 11 addr 0 → each gives `resp_misaligned`=1 after E0, `wEn` stays 0, memory unchanged.
- Reset asserted during RMW_READ, and separately during WRITE, of SB 0x11 to addr 4 → no `resp_valid`, word 1 unchanged, `req_ready`=1 the cycle after reset drops.
- `req_valid` held high with 5 LW requests → exactly 5 `resp_valid` pulses, each 3 cycles apart, `req_ready` low in LOAD/RESP.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and data width for the load/store unit
package lsu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extract/extend, store lane merge and misalignment detect
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged,
  output logic                  misaligned
);
  logic [4:0]            bsh;
  logic [DATA_WIDTH-1:0] sh;
  logic [DATA_WIDTH-1:0] mask;
  // lane shift, sign/zero extension, read-modify-write merge and alignment rules
  always_comb begin
    bsh        = {addr_lo, 3'b000};
    sh         = rdata >> bsh;
    load_data  = size == SIZE_B ? {{24{~is_unsigned & sh[7]}}, sh[7:0]} :
                 size == SIZE_H ? {{16{~is_unsigned & sh[15]}}, sh[15:0]} : rdata;
    mask       = (size == SIZE_B ? 32'h0000_00FF : 32'h0000_FFFF) << bsh;
    merged     = size == SIZE_W ? wdata : (rdata & ~mask) | ((wdata << bsh) & mask);
    misaligned = size == 2'b11 || (size == SIZE_H && addr_lo[0]) || (size == SIZE_W && addr_lo != 2'b00);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and read-modify-write stores on the ram data port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_misaligned,
  output logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_read_data,
  output logic [DATA_WIDTH-1:0] d_write_data,
  output logic                  wEn
);
  state_t                state, next;
  logic [1:0]            l_size, l_lo, a_size, a_lo;
  logic                  l_unsigned, accept, misaligned;
  logic [DATA_WIDTH-1:0] load_data, merged;
  logic                  unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
  lsu_lane_align u_align (
    .size       (a_size),
    .is_unsigned(l_unsigned),
    .addr_lo    (a_lo),
    .rdata      (d_read_data),
    .wdata      (d_write_data),
    .load_data  (load_data),
    .merged     (merged),
    .misaligned (misaligned)
  );
  // handshake outputs, aligner input select (live request in IDLE) and next state
  always_comb begin
    req_ready  = state == IDLE && !reset;
    wEn        = state == WRITE && !reset;
    resp_valid = state == RESP && !reset;
    accept     = req_valid && req_ready;
    a_size     = state == IDLE ? req_size : l_size;
    a_lo       = state == IDLE ? req_addr[1:0] : l_lo;
    next       = state == IDLE ? (!accept ? IDLE : misaligned ? RESP : !req_write ? LOAD :
                                  req_size == SIZE_W ? WRITE : RMW_READ) :
                 state == RMW_READ ? WRITE :
                 state == LOAD || state == WRITE ? RESP : IDLE;
  end
  // state register, request latch, load result and merged write word
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      l_size          <= 2'b00;
      l_lo            <= 2'b00;
      l_unsigned      <= 1'b0;
      d_address       <= '0;
      d_write_data    <= '0;
      resp_rdata      <= '0;
      resp_misaligned <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        l_size          <= req_size;
        l_lo            <= req_addr[1:0];
        l_unsigned      <= req_unsigned;
        d_address       <= req_addr[ADDR_WIDTH+1:2];
        d_write_data    <= req_wdata;
        resp_rdata      <= '0;
        resp_misaligned <= misaligned;
      end
      if (state == LOAD) resp_rdata <= load_data;
      if (state == RMW_READ) d_write_data <= merged;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench with a behavioural ram on the data port
module tb_load_store_unit;
  typedef struct packed {logic [31:0] rdata; logic mis;} exp_t;
  logic        clock = 0, reset = 1, init = 1;
  logic        req_valid = 0, req_write = 0, req_unsigned = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_misaligned, wEn;
  logic [31:0] resp_rdata, d_read_data, d_write_data;
  logic [15:0] d_address;
  logic [31:0] mem [0:65535];
  exp_t        sb_q[$];
  int          checks = 0, failures = 0;

  load_store_unit #(.ADDR_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned), .d_address(d_address),
    .d_read_data(d_read_data), .d_write_data(d_write_data), .wEn(wEn)
  );

  always #5 clock = ~clock;
  assign d_read_data = mem[d_address];
  always @(posedge clock) begin
    if (init) mem[1] <= 32'h8899AABB;
    else if (wEn) mem[d_address] <= d_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clock);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  task automatic drive(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid = 0; req_wdata = 32'h0BAD_0BAD; req_addr = 32'hFFFF_FFFF; req_size = 2'b11;
  endtask

  task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] wd, input int lat, input int wen_at,
                     input logic [31:0] er, input logic em);
    int k, wen_seen, wen_cnt;
    exp_t e;
    wen_seen = -1; wen_cnt = 0;
    wait_ready(tag);
    sb_q.push_back({er, em});
    drive(w, sz, u, a, wd);
    k = 0;
    while (!resp_valid && k < 10) begin
      if (wEn) begin wen_cnt++; wen_seen = k; end
      @(negedge clock);
      k++;
    end
    check({tag, "_lat"}, k, lat);
    check({tag, "_wen_cnt"}, wen_cnt, wen_at >= 0 ? 1 : 0);
    check({tag, "_wen_at"}, wen_seen, wen_at);
    if (resp_valid && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_rdata"}, resp_rdata, e.rdata);
      check({tag, "_mis"}, {31'd0, resp_misaligned}, {31'd0, e.mis});
      check({tag, "_ready_in_resp"}, {31'd0, req_ready}, 32'd0);
    end else check({tag, "_resp"}, {31'd0, resp_valid}, 32'd1);
    @(negedge clock);
    check({tag, "_pulse"}, {31'd0, resp_valid}, 32'd0);
  endtask

  task automatic rst_mid(input string tag, input int at);
    int rv;
    rv = 0;
    wait_ready(tag);
    drive(1'b1, 2'b00, 1'b0, 32'd4, 32'h11);
    for (int k = 0; k < at; k++) begin rv |= resp_valid; @(negedge clock); end
    check({tag, "_wen_pre"}, {31'd0, wEn}, at == 1 ? 32'd1 : 32'd0);
    reset = 1;
    #1 check({tag, "_wen_gated"}, {31'd0, wEn}, 32'd0);
    @(negedge clock);
    reset = 0;
    #1 check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    for (int k = 0; k < 6; k++) begin rv |= resp_valid; @(negedge clock); end
    check({tag, "_no_resp"}, rv, 32'd0);
    check({tag, "_mem1"}, mem[1], 32'h5A99AABB);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted, pulses, last, readies;
    exp_t e;
    repeat (3) @(negedge clock);
    init = 0;
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_wen", {31'd0, wEn}, 32'd0);
    check("rst_mis", {31'd0, resp_misaligned}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_daddr", {16'd0, d_address}, 32'd0);
    check("rst_wdata", d_write_data, 32'd0);
    reset = 0;
    @(negedge clock);
    txn("lb5",  1'b0, 2'b00, 1'b0, 32'd5, 32'd0, 1, -1, 32'hFFFFFFAA, 1'b0);
    txn("lbu5", 1'b0, 2'b00, 1'b1, 32'd5, 32'd0, 1, -1, 32'h000000AA, 1'b0);
    txn("lh6",  1'b0, 2'b01, 1'b0, 32'd6, 32'd0, 1, -1, 32'hFFFF8899, 1'b0);
    txn("lhu6", 1'b0, 2'b01, 1'b1, 32'd6, 32'd0, 1, -1, 32'h00008899, 1'b0);
    txn("sb7",  1'b1, 2'b00, 1'b0, 32'd7, 32'h5A, 2, 1, 32'd0, 1'b0);
    check("sb7_mem1", mem[1], 32'h5A99AABB);
    txn("lw4",  1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1, -1, 32'h5A99AABB, 1'b0);
    txn("sw8",  1'b1, 2'b10, 1'b0, 32'd8, 32'hDEADBEEF, 1, 0, 32'd0, 1'b0);
    txn("lw8",  1'b0, 2'b10, 1'b0, 32'd8, 32'd0, 1, -1, 32'hDEADBEEF, 1'b0);
    txn("shA",  1'b1, 2'b01, 1'b0, 32'hA, 32'hFFFFFFFF, 2, 1, 32'd0, 1'b0);
    check("shA_mem2", mem[2], 32'hFFFFBEEF);
    txn("lbu_wrap", 1'b0, 2'b00, 1'b1, 32'h0004_0009, 32'd0, 1, -1, 32'h000000BE, 1'b0);
    txn("mis_lw6", 1'b0, 2'b10, 1'b0, 32'd6, 32'd0, 0, -1, 32'd0, 1'b1);
    txn("mis_sh3", 1'b1, 2'b01, 1'b0, 32'd3, 32'h1234, 0, -1, 32'd0, 1'b1);
    txn("mis_sz3", 1'b1, 2'b11, 1'b0, 32'd0, 32'h77, 0, -1, 32'd0, 1'b1);
    check("mis_mem1", mem[1], 32'h5A99AABB);
    check("mis_mem2", mem[2], 32'hFFFFBEEF);
    rst_mid("rst_rmw", 0);
    rst_mid("rst_wr", 1);
    txn("post_rst_lw4", 1'b0, 2'b10, 1'b0, 32'd4, 32'd0, 1, -1, 32'h5A99AABB, 1'b0);
    accepted = 0; pulses = 0; last = -1; readies = 0;
    req_valid = 1; req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'd8;
    for (int c = 0; c < 30; c++) begin
      if (accepted == 5) req_valid = 0;
      if (resp_valid) begin
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("b2b_rdata", resp_rdata, e.rdata);
        end else check("b2b_unexpected", 32'd1, 32'd0);
        if (last >= 0) check("b2b_gap", c - last, 32'd3);
        check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
        last = c;
        pulses++;
      end
      if (req_valid && req_ready) begin
        readies++;
        accepted++;
        sb_q.push_back({32'hFFFFBEEF, 1'b0});
      end
      @(negedge clock);
    end
    check("b2b_pulses", pulses, 32'd5);
    check("b2b_readies", readies, 32'd5);
    check("b2b_q_empty", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
